// File: rtl/rv32i_pipe_ctrl.sv
// rv32i_pipe_ctrl: central stall/flush controller for the RV32I pipeline.
// Handles load-use hazards, taken branch/jump redirects, data-memory wait
// states, post-reset flushing, and a debug halt/single-step FSM. It also
// keeps saturating stall/flush event counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// INIT   | post-reset flush, fetch held for RESET_FLUSH_CYCLES cycles
// RUN    | normal operation, hazard resolution active
// DRAIN  | fetch stopped, bubbles injected until the back-end is empty
// HALTED | debug halt, whole pipe frozen
// STEP   | one cycle of free flow to let a single instruction in
module rv32i_pipe_ctrl #(
  parameter int NUM_STAGES         = 5,
  parameter int RESET_FLUSH_CYCLES = 2,
  parameter int CNT_W              = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [4:0]            id_rs1_addr_i,
  input  logic [4:0]            id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_memread_i,
  input  logic [4:0]            ex_rd_addr_i,
  input  logic                  bj_taken_i,
  input  logic                  mem_busy_i,
  input  logic                  dbg_halt_req_i,
  input  logic                  dbg_resume_i,
  input  logic                  dbg_step_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  halted_o,
  output logic [2:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3,
    S_STEP   = 3'd4
  } state_t;

  localparam int IW = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LOAD  = IW'(RESET_FLUSH_CYCLES - 1);
  // NUM_STAGES is at most 8, so the drain count fits in 3 bits.
  localparam logic [2:0]    DRAIN_LOAD = 3'(NUM_STAGES - 1);

  state_t                  r_state;
  logic [IW-1:0]           r_init_cnt;
  logic [2:0]              r_drain_cnt;
  logic                    r_halted;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [CNT_W-1:0]        r_flush_cnt;

  logic                    w_load_use;
  logic                    w_bj_flush;
  logic [NUM_STAGES-1:0]   w_stall;
  logic [NUM_STAGES-1:0]   w_flush;

  assign w_load_use = id_valid_i & ex_valid_i & ex_memread_i & (ex_rd_addr_i != 5'd0) &
                      ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                       (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

  // Per-stage hold/bubble decode from current state and hazard inputs.
  always_comb begin
    w_stall    = '0;
    w_flush    = '0;
    w_bj_flush = 1'b0;
    case (r_state)
      S_INIT: begin
        w_stall[0] = 1'b1;
        w_flush    = '1;
      end
      S_RUN: begin
        if (mem_busy_i) begin
          w_stall = '1;
        end else if (bj_taken_i) begin
          w_flush[0] = 1'b1;
          w_flush[1] = 1'b1;
          w_bj_flush = 1'b1;
        end else if (w_load_use) begin
          w_stall[0] = 1'b1;
          w_stall[1] = 1'b1;
          w_flush[2] = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_busy_i) begin
          w_stall = '1;
        end else begin
          // IF stays held; the flush wins inside IF when a redirect arrives.
          w_stall[0] = 1'b1;
          w_flush[0] = 1'b1;
          if (bj_taken_i) begin
            w_flush[1] = 1'b1;
            w_bj_flush = 1'b1;
          end
        end
      end
      S_HALTED: begin
        w_stall = '1;
      end
      default: begin
        w_stall = '0;
        w_flush = '0;
      end
    endcase
  end

  // Control FSM with drain/init timers, halted flag and event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_INIT;
      r_init_cnt  <= INIT_LOAD;
      r_drain_cnt <= DRAIN_LOAD;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_bj_flush && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == '0) begin
            r_state <= S_RUN;
          end else begin
            r_init_cnt <= r_init_cnt - IW'(1);
          end
        end
        S_RUN: begin
          if (w_stall[0] && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
          end
          if (dbg_halt_req_i) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (!mem_busy_i) begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
            if (r_drain_cnt == 3'd1) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          if (dbg_resume_i) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end else if (dbg_step_i) begin
            r_state  <= S_STEP;
            r_halted <= 1'b0;
          end
        end
        S_STEP: begin
          r_state     <= S_DRAIN;
          r_drain_cnt <= DRAIN_LOAD;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  assign stall_o     = w_stall;
  assign flush_o     = w_flush;
  assign halted_o    = r_halted;
  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// tb_rv32i_pipe_ctrl: two instances (5-stage/16-bit counters and
// 7-stage/4-bit counters) share stimulus and are compared every cycle
// against a cycle-level behavioural model of the control rules.
module tb_rv32i_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic ex_valid = 1'b0, memread = 1'b0, bj = 1'b0, busy = 1'b0;
  logic halt = 1'b0, resume = 1'b0, step = 1'b0;

  logic [4:0]  stall5, flush5;
  logic [6:0]  stall7, flush7;
  logic        halted5, halted7;
  logic [2:0]  state5, state7;
  logic [15:0] scnt5, fcnt5;
  logic [3:0]  scnt7, fcnt7;

  int n_tests = 0;
  int n_fail  = 0;

  // model state per instance: 0=5-stage, 1=7-stage
  int m_mode [2];
  int m_init [2];
  int m_drain[2];
  int m_scnt [2];
  int m_fcnt [2];
  int NS     [2] = '{5, 7};
  int CMAX   [2] = '{65535, 15};

  always #5 clk = ~clk;

  rv32i_pipe_ctrl u_dut5 (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_valid_i(ex_valid), .ex_memread_i(memread), .ex_rd_addr_i(rd),
    .bj_taken_i(bj), .mem_busy_i(busy),
    .dbg_halt_req_i(halt), .dbg_resume_i(resume), .dbg_step_i(step),
    .stall_o(stall5), .flush_o(flush5), .halted_o(halted5), .state_o(state5),
    .stall_cnt_o(scnt5), .flush_cnt_o(fcnt5)
  );

  rv32i_pipe_ctrl #(.NUM_STAGES(7), .RESET_FLUSH_CYCLES(2), .CNT_W(4)) u_dut7 (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_valid_i(ex_valid), .ex_memread_i(memread), .ex_rd_addr_i(rd),
    .bj_taken_i(bj), .mem_busy_i(busy),
    .dbg_halt_req_i(halt), .dbg_resume_i(resume), .dbg_step_i(step),
    .stall_o(stall7), .flush_o(flush7), .halted_o(halted7), .state_o(state7),
    .stall_cnt_o(scnt7), .flush_cnt_o(fcnt7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_init[k] = 2; m_drain[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
  endtask

  // Expected combinational outputs for instance k from the written rules.
  task automatic model_out(input int k, output int st, output int fl);
    int all_ones;
    bit lu;
    all_ones = (1 << NS[k]) - 1;
    lu = id_valid && ex_valid && memread && (rd != 0) &&
         ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
    st = 0; fl = 0;
    case (m_mode[k])
      0: begin st = 1; fl = all_ones; end
      1: begin
        if (busy) st = all_ones;
        else if (bj) fl = 3;
        else if (lu) begin st = 3; fl = 4; end
      end
      2: begin
        if (busy) st = all_ones;
        else begin st = 1; fl = bj ? 3 : 1; end
      end
      3: st = all_ones;
      default: begin st = 0; fl = 0; end
    endcase
  endtask

  task automatic model_step(input int k);
    int st, fl;
    model_out(k, st, fl);
    case (m_mode[k])
      0: begin m_init[k]--; if (m_init[k] == 0) m_mode[k] = 1; end
      1: begin
        if ((st & 1) && m_scnt[k] < CMAX[k]) m_scnt[k]++;
        if (!busy && bj && m_fcnt[k] < CMAX[k]) m_fcnt[k]++;
        if (halt) begin m_mode[k] = 2; m_drain[k] = NS[k] - 1; end
      end
      2: begin
        if (!busy && bj && m_fcnt[k] < CMAX[k]) m_fcnt[k]++;
        if (!busy) begin
          m_drain[k]--;
          if (m_drain[k] == 0) m_mode[k] = 3;
        end
      end
      3: begin
        if (resume) m_mode[k] = 1;
        else if (step) m_mode[k] = 4;
      end
      default: begin m_mode[k] = 2; m_drain[k] = NS[k] - 1; end
    endcase
  endtask

  // Called right after a negedge with inputs set; checks, advances, returns at next negedge.
  task automatic tick();
    int st, fl;
    #1;
    model_out(0, st, fl);
    chk("stall5", 32'(stall5), 32'(st));
    chk("flush5", 32'(flush5), 32'(fl));
    chk("state5", 32'(state5), 32'(m_mode[0]));
    chk("halted5", 32'(halted5), 32'(m_mode[0] == 3));
    chk("scnt5", 32'(scnt5), 32'(m_scnt[0]));
    chk("fcnt5", 32'(fcnt5), 32'(m_fcnt[0]));
    model_out(1, st, fl);
    chk("stall7", 32'(stall7), 32'(st));
    chk("flush7", 32'(flush7), 32'(fl));
    chk("state7", 32'(state7), 32'(m_mode[1]));
    chk("halted7", 32'(halted7), 32'(m_mode[1] == 3));
    chk("scnt7", 32'(scnt7), 32'(m_scnt[1]));
    chk("fcnt7", 32'(fcnt7), 32'(m_fcnt[1]));
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    id_valid = 0; rs1_used = 0; rs2_used = 0; rs1 = 0; rs2 = 0; rd = 0;
    ex_valid = 0; memread = 0; bj = 0; busy = 0; halt = 0; resume = 0; step = 0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    id_valid = 1; ex_valid = 1; memread = 1; rd = r; rs1 = r; rs1_used = 1;
    rs2 = 5'd1; rs2_used = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    // INIT: two flushing cycles, then RUN with quiet outputs
    tick();
    tick();
    #1;
    chk("run_state", 32'(state5), 32'd1);
    chk("run_stall", 32'(stall5), 32'd0);
    tick();

    // load-use on x5
    set_lu(5'd5);
    #1;
    chk("lu_stall", 32'(stall5), 32'h03);
    chk("lu_flush", 32'(flush5), 32'h04);
    tick();
    clear_in();
    #1;
    chk("lu_cnt", 32'(scnt5), 32'd1);
    tick();
    // rd = x0 is never a hazard
    set_lu(5'd0);
    #1;
    chk("lu_x0", 32'(stall5), 32'h00);
    tick();

    // branch beats load-use
    set_lu(5'd7); bj = 1;
    #1;
    chk("bj_flush", 32'(flush5), 32'h03);
    chk("bj_stall", 32'(stall5), 32'h00);
    tick();
    #1;
    chk("bj_cnt", 32'(fcnt5), 32'd1);
    // busy holds the branch for 3 cycles, then it flushes
    busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_stall", 32'(stall5), 32'h1F);
      tick();
    end
    busy = 0;
    #1;
    chk("busy_then_flush", 32'(flush5), 32'h03);
    tick();
    clear_in();
    tick();

    // halt: 4 drain cycles on the 5-stage instance, 6 on the 7-stage one
    halt = 1;
    tick();
    halt = 0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("halted5", 32'(halted5), 32'd1);
    chk("halt_stall5", 32'(stall5), 32'h1F);
    chk("still_drain7", 32'(state7), 32'd2);
    tick();
    tick();
    #1;
    chk("halted7", 32'(halted7), 32'd1);

    // single step
    step = 1;
    tick();
    step = 0;
    #1;
    chk("step_stall", 32'(stall5), 32'h00);
    chk("step_flush", 32'(flush5), 32'h00);
    chk("step_nohalt", 32'(halted5), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("step_rehalt5", 32'(halted5), 32'd1);
    chk("step_rehalt7", 32'(halted7), 32'd1);

    // resume beats step
    resume = 1; step = 1;
    tick();
    clear_in();
    #1;
    chk("resume_run", 32'(state5), 32'd1);
    tick();

    // reset in the middle of the 7-stage drain
    halt = 1;
    tick();
    halt = 0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_state7", 32'(state7), 32'd0);
    chk("rst_scnt7", 32'(scnt7), 32'd0);
    chk("rst_fcnt7", 32'(fcnt7), 32'd0);
    chk("rst_flush5", 32'(flush5), 32'h1F);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // saturation of the 4-bit stall counter
    busy = 1;
    for (int i = 0; i < 20; i++) tick();
    busy = 0;
    #1;
    chk("sat_scnt7", 32'(scnt7), 32'hF);
    tick();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      clear_in();
      busy     = ($urandom_range(0, 4) == 0);
      bj       = ($urandom_range(0, 6) == 0);
      id_valid = $urandom_range(0, 1);
      ex_valid = $urandom_range(0, 1);
      memread  = $urandom_range(0, 1);
      rs1_used = $urandom_range(0, 1);
      rs2_used = $urandom_range(0, 1);
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rd       = 5'($urandom_range(0, 3));
      halt     = ($urandom_range(0, 29) == 0);
      resume   = ($urandom_range(0, 9) == 0);
      step     = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_pipe_ctrl.md
# rv32i_pipe_ctrl

Parametrised pipeline control unit for the RV32I core that drives the per-stage `stall`/`flush` inputs of IF, ID, EX and the back-end stages from one place. It resolves load-use hazards, taken branch/jump redirects and data-memory wait states. It also runs post-reset flushing and a debug halt/single-step FSM. Stage count is a parameter, so deeper back-ends (split MEM, extra WB) reuse the same block; the unit also exposes saturating stall/flush event counters.

## Interface
- `NUM_STAGES`, 5: pipeline stages, legal 5..8. Index 0=IF, 1=ID, 2=EX, 3..NUM_STAGES-1 = back-end (MEM, WB, extra).
- `RESET_FLUSH_CYCLES`, 2: cycles spent in INIT after reset release, legal ≥1.
- `CNT_W`, 16: event counter width.
- `clk_i`  in  1  core clock; all state updates on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `id_valid_i`  in  1  valid instruction in ID.
- `id_rs1_addr_i`, `id_rs2_addr_i`  in  5  ID source registers.
- `id_rs1_used_i`, `id_rs2_used_i`  in  1  source register actually read.
- `ex_valid_i`  in  1  valid instruction in EX.
- `ex_memread_i`  in  1  EX instruction is a load.
- `ex_rd_addr_i`  in  5  EX destination register.
- `bj_taken_i`  in  1  EX resolved a taken branch/JAL/JALR.
- `mem_busy_i`  in  1  data memory not ready this cycle.
- `dbg_halt_req_i`, `dbg_resume_i`, `dbg_step_i`  in  1  debug requests, single-cycle pulses.
- `stall_o`  out  NUM_STAGES  per-stage hold.
- `flush_o`  out  NUM_STAGES  per-stage bubble insert into that stage's output register.
- `halted_o`  out  1  core fully drained and halted.
- `state_o`  out  3  FSM state: INIT=0, RUN=1, DRAIN=2, HALTED=3, STEP=4.
- `stall_cnt_o`  out  CNT_W  cycles with `stall_o[0]`=1 while in RUN.
- `flush_cnt_o`  out  CNT_W  taken `bj_taken_i` flush events.

## Operation
- **FSM state:** registered. `stall_o`/`flush_o` are combinational from state and inputs. `halted_o`, `state_o` and the counters are registered.
- **INIT:**
  - Outputs: `stall_o[0]`=1, `flush_o` all ones, other stalls 0.
  - Exit: after RESET_FLUSH_CYCLES cycles → RUN.
- **RUN:** conditions are evaluated in priority order.
  1. `mem_busy_i`: `stall_o` all ones, `flush_o` all zero. A pending branch stays held in EX and is flushed on the first non-busy cycle.
  2. `bj_taken_i`: `flush_o[0]`=1 and `flush_o[1]`=1, no stalls. `flush_cnt_o`+1. A simultaneous load-use condition is ignored.
  3. Load-use, defined as `id_valid_i & ex_valid_i & ex_memread_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd))`:
     - Outputs: `stall_o[0]`=`stall_o[1]`=1, `flush_o[2]`=1, all else 0.
  4. Otherwise all zero.
- **`stall_cnt_o`:** +1 on every RUN cycle where `stall_o[0]`=1.
- **Halt request in RUN:** `dbg_halt_req_i` in RUN → DRAIN with drain counter = NUM_STAGES-1. The RUN outputs of that cycle still apply.
- **DRAIN:**
  - Outputs: `stall_o[0]`=1, `flush_o[0]`=1, which stops fetch and injects bubbles. `mem_busy_i` and `bj_taken_i` rules apply as in RUN.
  - Counter: decrements on non-busy cycles. At 0 → HALTED.
  - Redirects: a branch taken during DRAIN still flushes. The IF redirect takes priority over `stall_i` inside IF.
- **HALTED:**
  - Outputs: `stall_o` all ones, `flush_o` 0, `halted_o`=1.
  - `dbg_resume_i` → RUN.
  - Otherwise `dbg_step_i` → STEP. Resume beats step when both are asserted in the same cycle.
- **STEP:** exactly one cycle.
  - Outputs: stall/flush all zero, so one instruction is fetched and the rest of the pipe advances.
  - Then → DRAIN with counter reloaded to NUM_STAGES-1.
- **Ignored requests:** halt request outside RUN, and resume/step outside HALTED.
- **Counters:** saturate at all-ones and never wrap.

## Timing
- **Reset values:** `state_o`=INIT, `halted_o`=0, counters 0, `stall_o`=1 (bit 0 only), `flush_o` all ones.
- **Reset behaviour:** asserting `rst_ni` mid-operation (any state) returns immediately to these values. INIT restarts on release.
- **Hazard outputs:** zero-latency, valid in the same cycle as the causing inputs.
- **Load-use:** stalls exactly one cycle, because the next cycle the load has left EX.
- **Halt latency:** from the `dbg_halt_req_i` edge to `halted_o`=1 is 1 + (NUM_STAGES-1) + (busy cycles) cycles.
- **Single step:** retires one instruction. `halted_o` drops for the STEP cycle plus the DRAIN cycles.

## Test plan
- **Reset, INIT, first RUN cycle:** release `rst_ni`, no other stimulus → `flush_o`=5'b11111 and `stall_o`=5'b00001 for 2 cycles, then `state_o`=1 with `stall_o`=`flush_o`=0.
- **Load-use:** `lw x5` in EX, `add x6,x5,x1` in ID with `rs1_used`=1 → one cycle of `stall_o`=5'b00011, `flush_o`=5'b00100, `stall_cnt_o`=1. Repeat with `rd`=x0 → no stall.
- **Branch vs load-use vs busy:**
  - `bj_taken_i` with a simultaneous load-use → `flush_o`=5'b00011, no stall, `flush_cnt_o`=1.
  - Same stimulus with `mem_busy_i`=1 for 3 cycles → 3 cycles of `stall_o`=5'b11111, then the flush.
- **Halt/step/resume, NUM_STAGES=5:**
  - Halt pulse → DRAIN for 4 cycles, then `halted_o`=1 and `stall_o`=5'b11111.
  - Step → one cycle of all-zero outputs, then 4 DRAIN cycles, then HALTED.
  - Resume together with step → RUN.
- **NUM_STAGES=7 plus reset mid-DRAIN:** drain takes 6 cycles. Asserting `rst_ni` low mid-DRAIN → `state_o`=0 and counters 0 immediately.
- **Counter saturation:** `CNT_W`=4 with 20 busy cycles → `stall_cnt_o` holds 4'hF.
